// File: rtl/sunflower_pkg.sv
// Shared definitions for the sunflower light optimizer: FSM states, default
// sizes and the per-position averaging constants.
package sunflower_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam int DEFAULT_W     = 12;
    localparam int DEFAULT_N_POS = 16;
    localparam int AVG_COUNT     = 4;
    localparam int AVG_SHIFT     = 2;

endpackage

// File: rtl/sample_averager.sv
// Averages AVG_COUNT consecutive samples per panel position.
// Compiled only when PEAK_AVG_EN is defined.
`ifdef PEAK_AVG_EN
module sample_averager
    import sunflower_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [W-1:0] sample,
    output logic         avg_valid,
    output logic [W-1:0] avg_value
);

    logic [AVG_SHIFT-1:0] cnt;
    logic [W+1:0]         sum;
    logic [W+1:0]         sum_nxt;

    // The final sample of a group is folded in combinationally so the tracker
    // sees the average in the same cycle as the 4th sample.
    assign sum_nxt   = sum + (W+2)'(sample);
    assign avg_valid = in_valid && (cnt == AVG_SHIFT'(AVG_COUNT - 1));
    assign avg_value = sum_nxt[W+1:AVG_SHIFT];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sum <= '0;
        end else if (clear || avg_valid) begin
            cnt <= '0;
            sum <= '0;
        end else if (in_valid) begin
            cnt <= cnt + 1'b1;
            sum <= sum_nxt;
        end
    end

endmodule
`endif

// File: rtl/peak_position_tracker.sv
// Sweep-based peak detector: steps pos_idx over N_POS positions and reports the
// largest sample and its position. Define PEAK_AVG_EN to average 4 samples/position.
module peak_position_tracker
    import sunflower_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int N_POS = DEFAULT_N_POS,
    parameter int IDX_W = $clog2(N_POS)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [W-1:0]     sample,
    output logic [IDX_W-1:0] pos_idx,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     peak_value,
    output logic [IDX_W-1:0] peak_idx
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(N_POS - 1);

    state_t         state, state_nxt;
    logic           start_sweep;
    logic           sweep_valid;
    logic           acc_valid;
    logic [W-1:0]   acc_value;
    logic           last_pos;

    assign start_sweep = (state == IDLE) && start;
    assign sweep_valid = (state == SWEEP) && sample_valid;
    assign last_pos    = (pos_idx == LAST_POS);

`ifdef PEAK_AVG_EN
    sample_averager #(.W(W)) u_sample_averager (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .clear     (start_sweep),
        .in_valid  (sweep_valid),
        .sample    (sample),
        .avg_valid (acc_valid),
        .avg_value (acc_value)
    );
`else
    assign acc_valid = sweep_valid;
    assign acc_value = sample;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (acc_valid && last_pos) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strict compare keeps the earliest index on ties; pos_idx parks on the last position.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pos_idx    <= '0;
            peak_value <= '0;
            peak_idx   <= '0;
        end else if (start_sweep) begin
            pos_idx    <= '0;
            peak_value <= '0;
            peak_idx   <= '0;
        end else if (acc_valid) begin
            if (acc_value > peak_value) begin
                peak_value <= acc_value;
                peak_idx   <= pos_idx;
            end
            if (!last_pos) pos_idx <= pos_idx + 1'b1;
        end
    end

    assign busy = (state == SWEEP);
    assign done = (state == FIN);

endmodule

// File: tb/tb_peak_position_tracker.sv
// Randomized self-checking bench for peak_position_tracker against a sweep-level
// reference model; follows PEAK_AVG_EN when it is defined for the build.
module tb_peak_position_tracker;

    localparam int W     = 12;
    localparam int N_POS = 16;
    localparam int IDX_W = 4;
`ifdef PEAK_AVG_EN
    localparam int SPP = 4;
`else
    localparam int SPP = 1;
`endif
    localparam int NS = N_POS * SPP;

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic             start    = 1'b0;
    logic             sample_valid = 1'b0;
    logic [W-1:0]     sample   = '0;
    logic [IDX_W-1:0] pos_idx;
    logic             busy;
    logic             done;
    logic [W-1:0]     peak_value;
    logic [IDX_W-1:0] peak_idx;

    int vecs = 0;
    int errs = 0;
    int smp [NS];
    int last_pv = 0;
    int last_pi = 0;

    peak_position_tracker #(.W(W), .N_POS(N_POS), .IDX_W(IDX_W)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .pos_idx      (pos_idx),
        .busy         (busy),
        .done         (done),
        .peak_value   (peak_value),
        .peak_idx     (peak_idx)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_val(input string tag, input int got, input int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Peak over the first npos positions: per-position mean (floor), strict > wins.
    function automatic void ref_peak(input int npos, output int pv, output int pi);
        int s;
        int a;
        pv = 0;
        pi = 0;
        for (int p = 0; p < npos; p++) begin
            s = 0;
            for (int j = 0; j < SPP; j++) s += smp[p*SPP + j];
            a = s / SPP;
            if (a > pv) begin
                pv = a;
                pi = p;
            end
        end
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_idle(input string tag, input int pv, input int pi);
        check_val({tag, ".busy"}, int'(busy), 0);
        check_val({tag, ".done"}, int'(done), 0);
        check_val({tag, ".peak_value"}, int'(peak_value), pv);
        check_val({tag, ".peak_idx"}, int'(peak_idx), pi);
    endtask

    task automatic run_sweep(input string tag, input int gap, input int mid_start_k);
        int pv;
        int pi;
        int npos;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val({tag, ".start_busy"}, int'(busy), 1);
        check_val({tag, ".start_pos"}, int'(pos_idx), 0);
        check_val({tag, ".start_peak"}, int'(peak_value), 0);
        for (int k = 0; k < NS; k++) begin
            for (int g = 0; g < gap; g++) begin
                sample_valid = 1'b0;
                sample = W'($urandom);
                step();
            end
            sample_valid = 1'b1;
            sample = W'(smp[k]);
            if (k == mid_start_k) start = 1'b1;
            step();
            sample_valid = 1'b0;
            start = 1'b0;
            npos = (k + 1) / SPP;
            ref_peak(npos, pv, pi);
            if (k == NS - 1) begin
                check_val({tag, ".done"}, int'(done), 1);
                check_val({tag, ".busy_end"}, int'(busy), 0);
                check_val({tag, ".pos_end"}, int'(pos_idx), N_POS - 1);
            end else begin
                check_val({tag, ".no_done"}, int'(done), 0);
                check_val({tag, ".busy"}, int'(busy), 1);
                check_val({tag, ".pos"}, int'(pos_idx), npos);
            end
            check_val({tag, ".run_peak"}, int'(peak_value), pv);
            check_val({tag, ".run_idx"}, int'(peak_idx), pi);
        end
        last_pv = pv;
        last_pi = pi;
        step();
        check_idle({tag, ".post"}, pv, pi);
    endtask

    task automatic idle_noise(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            sample_valid = 1'($urandom);
            sample = W'($urandom);
            step();
            check_idle(tag, last_pv, last_pi);
        end
        sample_valid = 1'b0;
    endtask

    task automatic fill_random(input int maxv);
        for (int k = 0; k < NS; k++) smp[k] = int'($urandom_range(0, maxv));
    endtask

    initial begin
        repeat (2) @(posedge CLOCK_50);
        #1;
        check_val("reset.pos", int'(pos_idx), 0);
        check_idle("reset", 0, 0);
        reset = 1'b0;
        idle_noise("idle_noise", 12);
        check_val("idle.pos", int'(pos_idx), 0);

        // Single peak of 4000 at position 9 over a 100,200,... ramp
        for (int p = 0; p < N_POS; p++)
            for (int j = 0; j < SPP; j++) smp[p*SPP + j] = (p == 9) ? 4000 : 100 * (p + 1);
        run_sweep("single_peak", 0, -1);
        check_val("single_peak.value", int'(peak_value), 4000);
        check_val("single_peak.idx", int'(peak_idx), 9);

        // Tie at full scale: earliest index wins
        for (int k = 0; k < NS; k++) smp[k] = int'($urandom_range(0, 4000));
        for (int j = 0; j < SPP; j++) begin
            smp[3*SPP + j]  = 12'hFFF;
            smp[12*SPP + j] = 12'hFFF;
        end
        run_sweep("tie", 0, -1);
        check_val("tie.idx", int'(peak_idx), 3);

        for (int k = 0; k < NS; k++) smp[k] = 0;
        run_sweep("zeros", 0, -1);
        check_val("zeros.value", int'(peak_value), 0);
        check_val("zeros.idx", int'(peak_idx), 0);
        idle_noise("idle_after_zero", 5);

        fill_random(4095);
        run_sweep("mid_start", 0, 5);
        idle_noise("idle_hold", 6);

        fill_random(4095);
        run_sweep("gapped", 2, -1);
        run_sweep("b2b_same", 0, -1);

        for (int r = 0; r < 6; r++) begin
            fill_random((r % 2 == 0) ? 7 : 4095);
            run_sweep("random", int'($urandom_range(0, 2)), -1);
            idle_noise("random_idle", int'($urandom_range(0, 3)));
        end

        // Reset mid-sweep after 7 samples
        fill_random(4095);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7 * SPP; k++) begin
            sample_valid = 1'b1;
            sample = W'(smp[k]);
            step();
        end
        sample_valid = 1'b0;
        #4 reset = 1'b1;
        #1;
        check_val("rst_mid.pos", int'(pos_idx), 0);
        check_idle("rst_mid", 0, 0);
        step();
        reset = 1'b0;
        last_pv = 0;
        last_pi = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("rst_after", 0, 0);
        end
        fill_random(4095);
        run_sweep("after_reset", 0, -1);

`ifdef PEAK_AVG_EN
        for (int p = 0; p < N_POS; p++) begin
            smp[p*4 + 0] = (p == 4) ? 2000 : 999;
            smp[p*4 + 1] = (p == 4) ? 2001 : 1000;
            smp[p*4 + 2] = (p == 4) ? 2002 : 1001;
            smp[p*4 + 3] = (p == 4) ? 2003 : 1000;
        end
        run_sweep("avg", 0, -1);
        check_val("avg.value", int'(peak_value), 2001);
        check_val("avg.idx", int'(peak_idx), 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
